ps2_transmitter: RTL and testbench

Host-to-device PS/2 transmitter for the mouse interface. It sends one command byte to the device (for example 0xF4 "enable reporting") over the open-drain PS/2 clock and data lines:
- request-to-send inhibit;
- start bit, 8 data bits LSB first, odd parity, stop bit;
- device acknowledge check.

It sits beside the existing PS/2 receiver. Its `tx_idle` output gates the receiver's `rx_en`, so the two never contend for the bus.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_clk_filter.sv | 41 ++++
 rtl/ps2_transmitter.sv | 131 +++++++++++++
 tb/tb_ps2_transmitter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: state encodings, filter length and host command bytes.
package ps2_pkg;

    localparam int unsigned PS2_FILTER_LEN = 8;

    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    typedef enum logic [2:0] {
        StIdle,
        StRts,
        StStart,
        StData,
        StStop,
        StAck,
        StDone
    } ps2_state_e;

    // Odd parity: the 9-bit {parity, data} word always carries an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock deglitcher with a falling-edge strobe on the filtered clock.
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = PS2_FILTER_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic ps_c,
    output logic psc_f,
    output logic fall
);

    logic [FILTER_LEN-1:0] filter_q, filter_d;
    logic                  psc_f_q, psc_f_d;

    // Shift in the raw pad every cycle; the filtered level moves only on a full run.
    always_comb begin
        filter_d = {ps_c, filter_q[FILTER_LEN-1:1]};
        psc_f_d  = psc_f_q;
        if (&filter_q) begin
            psc_f_d = 1'b1;
        end else if (~|filter_q) begin
            psc_f_d = 1'b0;
        end
        fall  = psc_f_q & ~psc_f_d;
        psc_f = psc_f_q;
    end

    // Filter state; reset clears to the all-zero (clock low) view.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filter_q <= '0;
            psc_f_q  <= 1'b0;
        end else begin
            filter_q <= filter_d;
            psc_f_q  <= psc_f_d;
        end
    end

endmodule

// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame, device ack check.
module ps2_transmitter
    import ps2_pkg::*;
#(
    parameter int unsigned RTS_CYCLES = 8192,
    parameter int unsigned FILTER_LEN = PS2_FILTER_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps_c,
    inout  wire        ps_d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       ack_err
);

    localparam int unsigned RtsW = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;

    ps2_state_e      state_q, state_d;
    logic [8:0]      b_q, b_d;
    logic [RtsW-1:0] rts_q, rts_d;
    logic [3:0]      n_q, n_d;
    logic            ack_err_q, ack_err_d;
    logic            psd_q;
    logic            fall;
    logic            unused_psc_f;
    logic            drive_c_low, drive_d_low;

    ps2_clk_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk  (clk),
        .reset(reset),
        .ps_c (ps_c),
        .psc_f(unused_psc_f),
        .fall (fall)
    );

    // State and datapath registers; ps_d is registered before the ack sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            b_q       <= '0;
            rts_q     <= '0;
            n_q       <= '0;
            ack_err_q <= 1'b0;
            psd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            b_q       <= b_d;
            rts_q     <= rts_d;
            n_q       <= n_d;
            ack_err_q <= ack_err_d;
            psd_q     <= ps_d;
        end
    end

    // Next-state and datapath updates; every post-rts step advances on a filtered fall.
    always_comb begin
        state_d   = state_q;
        b_d       = b_q;
        rts_d     = rts_q;
        n_d       = n_q;
        ack_err_d = ack_err_q;
        unique case (state_q)
            StIdle: begin
                if (wr_ps2) begin
                    b_d       = {odd_parity(din), din};
                    rts_d     = RtsW'(RTS_CYCLES - 1);
                    ack_err_d = 1'b0;
                    state_d   = StRts;
                end
            end
            StRts: begin
                if (rts_q == '0) begin
                    state_d = StStart;
                end else begin
                    rts_d = rts_q - RtsW'(1);
                end
            end
            StStart: begin
                if (fall) begin
                    n_d     = 4'd8;
                    state_d = StData;
                end
            end
            StData: begin
                if (fall) begin
                    b_d = {1'b0, b_q[8:1]};
                    if (n_q == 4'd0) begin
                        state_d = StStop;
                    end else begin
                        n_d = n_q - 4'd1;
                    end
                end
            end
            StStop: begin
                if (fall) begin
                    state_d = StAck;
                end
            end
            StAck: begin
                if (fall) begin
                    ack_err_d = psd_q;
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Moore outputs and open-drain line controls, decoded from the current state.
    always_comb begin
        tx_idle      = (state_q == StIdle);
        tx_done_tick = (state_q == StDone);
        ack_err      = ack_err_q;
        drive_c_low  = (state_q == StRts);
        drive_d_low  = (state_q == StStart) || ((state_q == StData) && !b_q[0]);
    end

    assign ps_c = drive_c_low ? 1'b0 : 1'bz;
    assign ps_d = drive_d_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_transmitter.sv
// Self-checking bench for ps2_transmitter with a behavioural PS/2 device.
module tb_ps2_transmitter;
    import ps2_pkg::*;

    localparam int unsigned RTS  = 16;
    localparam int unsigned FLEN = PS2_FILTER_LEN;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_ps2;
    logic [7:0] din;
    wire        ps_c;
    wire        ps_d;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       ack_err;

    logic dev_c_low  = 1'b0;
    logic dev_d_low  = 1'b0;
    logic glitch_low = 1'b0;

    pullup (ps_c);
    pullup (ps_d);
    assign ps_c = (dev_c_low | glitch_low) ? 1'b0 : 1'bz;
    assign ps_d = dev_d_low ? 1'b0 : 1'bz;

    ps2_transmitter #(
        .RTS_CYCLES(RTS),
        .FILTER_LEN(FLEN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_ps2      (wr_ps2),
        .din         (din),
        .ps_c        (ps_c),
        .ps_d        (ps_d),
        .tx_idle     (tx_idle),
        .tx_done_tick(tx_done_tick),
        .ack_err     (ack_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   vectors     = 0;
    int   miscompares = 0;
    int   tick_cnt    = 0;
    int   tick_cyc    = 0;
    logic ack_at_tick = 1'b0;
    bit   in_frame    = 1'b0;
    int   idle_bad    = 0;

    // Count done pulses, latch ack_err at each, and flag tx_idle inside a frame.
    always @(negedge clk) begin
        if (tx_done_tick) begin
            tick_cnt++;
            tick_cyc    = cyc;
            ack_at_tick = ack_err;
            in_frame    = 1'b0;
        end else if (in_frame && tx_idle) begin
            idle_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame as the device should see it: start, d0..d7, odd parity, stop.
    function automatic logic [10:0] ref_frame(input logic [7:0] d);
        int          ones = 0;
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = d[i];
            ones += int'(d[i]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic write_byte(input logic [7:0] d);
        din    = d;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
    endtask

    task automatic wait_rts(input string tag);
        int low = 0;
        while (ps_c === 1'b0 && low < 5000) begin
            low++;
            @(negedge clk);
        end
        check({tag, ".rts_len"}, low, RTS);
        check({tag, ".start_d"}, ps_d, 1'b0);
    endtask

    // Device model: samples data just before each clock fall, then clocks the ack bit.
    task automatic device(input int half, input bit give_ack, input int glitch_at,
                          input int busy_at, input int abort_at,
                          output logic [10:0] got, output int fall12);
        int k;
        got    = '1;
        fall12 = 0;
        repeat (20) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            got[i]    = ps_d;
            dev_c_low = 1'b1;
            repeat (half) @(negedge clk);
            dev_c_low = 1'b0;
            if (i == abort_at) begin
                repeat (15) @(negedge clk);
                return;
            end
            if (i == glitch_at) begin
                repeat (10) @(negedge clk);
                glitch_low = 1'b1;
                repeat (3) @(negedge clk);
                glitch_low = 1'b0;
                repeat (half - 13) @(negedge clk);
            end else if (i == busy_at) begin
                repeat (5) @(negedge clk);
                din    = CMD_RESET;
                wr_ps2 = 1'b1;
                @(negedge clk);
                wr_ps2 = 1'b0;
                repeat (half - 6) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
        end
        if (give_ack) dev_d_low = 1'b1;
        repeat (5) @(negedge clk);
        dev_c_low = 1'b1;
        fall12    = cyc;
        k = 0;
        while (!tx_done_tick && k < half) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        dev_c_low = 1'b0;
        dev_d_low = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input int half, input bit give_ack,
                              input int glitch_at, input int busy_at, input string tag);
        int          t0 = tick_cnt;
        int          k;
        int          f12;
        logic [10:0] got;
        write_byte(d);
        in_frame = 1'b1;
        check({tag, ".busy"}, tx_idle, 1'b0);
        wait_rts(tag);
        device(half, give_ack, glitch_at, busy_at, -1, got, f12);
        k = 0;
        while (tick_cnt == t0 && k < 300) begin
            k++;
            @(negedge clk);
        end
        check({tag, ".bits"}, got, ref_frame(d));
        check({tag, ".ack_err"}, ack_at_tick, !give_ack);
        check({tag, ".tick_lat"}, tick_cyc - f12, FLEN + 1);
        check({tag, ".ticks"}, tick_cnt - t0, 1);
        check({tag, ".idle_after"}, tx_idle, 1'b1);
        check({tag, ".idle_in_frame"}, idle_bad, 0);
    endtask

    initial begin
        logic [7:0]  d;
        logic [10:0] got;
        int          f12;
        int          t0;
        int          half;
        bit          ack;

        reset  = 1'b1;
        wr_ps2 = 1'b0;
        din    = '0;
        repeat (3) @(negedge clk);
        check("rst.tx_idle", tx_idle, 1'b1);
        check("rst.tick", tx_done_tick, 1'b0);
        check("rst.ack_err", ack_err, 1'b0);
        check("rst.ps_c", ps_c, 1'b1);
        check("rst.ps_d", ps_d, 1'b1);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        send_frame(CMD_ENABLE, 40, 1'b1, -1, -1, "f4");
        repeat (30) @(negedge clk);
        send_frame(8'h00, 40, 1'b0, -1, -1, "zero");
        repeat (30) @(negedge clk);

        d = 8'($urandom);
        send_frame(d, 40, 1'b1, -1, 4, "busy");
        t0 = tick_cnt;
        repeat (100) @(negedge clk);
        check("busy.no_2nd_idle", tx_idle, 1'b1);
        check("busy.no_2nd_ps_c", ps_c, 1'b1);
        check("busy.no_2nd_tick", tick_cnt - t0, 0);

        d = 8'($urandom);
        send_frame(d, 40, 1'b1, 3, -1, "glitch");
        repeat (30) @(negedge clk);

        // Reset while the host drives a 0 data bit mid-frame.
        d  = 8'($urandom) & 8'hDF;
        t0 = tick_cnt;
        write_byte(d);
        in_frame = 1'b1;
        wait_rts("rstmid");
        device(40, 1'b1, -1, -1, 5, got, f12);
        check("rstmid.pre_d", ps_d, 1'b0);
        reset = 1'b1;
        #1;
        check("rstmid.ps_c", ps_c, 1'b1);
        check("rstmid.ps_d", ps_d, 1'b1);
        check("rstmid.tx_idle", tx_idle, 1'b1);
        check("rstmid.tick", tx_done_tick, 1'b0);
        in_frame = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check("rstmid.no_tick", tick_cnt - t0, 0);
        check("rstmid.idle", tx_idle, 1'b1);

        send_frame(CMD_RESET, 40, 1'b1, -1, -1, "b2b0");
        send_frame(CMD_ENABLE, 40, 1'b1, -1, -1, "b2b1");
        repeat (30) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            d    = 8'($urandom);
            half = int'($urandom_range(30, 50));
            ack  = 1'($urandom_range(0, 1));
            send_frame(d, half, ack, -1, -1, $sformatf("rnd%0d", i));
            repeat (20) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
